// File: rtl/geofence_host_if.sv
// rtl/geofence_host_if.sv - ROM read port and geofence engine point/result bus
interface geofence_host_if #(
  parameter int ADDR_W = 7
);
  logic              pt_rd;
  logic [ADDR_W-1:0] pt_addr;
  logic [19:0]       pt_rdata;
  logic              gf_reset;
  logic [9:0]        X;
  logic [9:0]        Y;
  logic              valid;
  logic              is_inside;

  modport master (
    output pt_rd, pt_addr, gf_reset, X, Y,
    input  pt_rdata, valid, is_inside
  );

  modport slave (
    input  pt_rd, pt_addr, gf_reset, X, Y,
    output pt_rdata, valid, is_inside
  );
endinterface

// File: rtl/geofence_host.sv
// rtl/geofence_host.sv - drives the geofence engine from ROM point groups and scores its results
module geofence_host #(
  parameter int NUM_GROUPS = 16,
  parameter int ADDR_W     = 7,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  geofence_host_if.master       gf,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic                  fail_seen,
  output logic [ADDR_W-4:0]     first_fail,
  output logic                  timeout_err
);
  localparam int GW  = ADDR_W - 3;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT, DONE} state_t;

  state_t         state, stateNext;
  logic [3:0]     step;
  logic [GW-1:0]  group;
  logic [WDW-1:0] watchdog;
  logic [19:0]    ptBuf [0:7];

  logic validHit, timeoutHit, groupEnd, isFail, lastGroup;

  assign validHit   = (state == WAIT) && gf.valid;
  assign timeoutHit = (state == WAIT) && !gf.valid && (watchdog == WDW'(TIMEOUT - 1));
  assign groupEnd   = validHit || timeoutHit;
  assign isFail     = timeoutHit || (validHit && (gf.is_inside != ptBuf[7][0]));
  assign lastGroup  = (group == GW'(NUM_GROUPS - 1));

  // ROM port decodes straight from state so the read lines up with the f_i cycle
  assign gf.pt_rd   = (state == FETCH) && !step[3];
  assign gf.pt_addr = gf.pt_rd ? {group, step[2:0]} : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (start) stateNext = FETCH;
      FETCH:      if (step == 4'd8) stateNext = SEND;
      SEND:       if (step == 4'd6) stateNext = WAIT;
      WAIT:       if (groupEnd) stateNext = lastGroup ? DONE : FETCH;
      default:    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gf.gf_reset <= 1'b1;
      gf.X        <= '0;
      gf.Y        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      fail_seen   <= 1'b0;
      first_fail  <= '0;
      timeout_err <= 1'b0;
      step        <= '0;
      group       <= '0;
      watchdog    <= '0;
    end else begin
      busy <= (stateNext == FETCH) || (stateNext == SEND) || (stateNext == WAIT);
      done <= (stateNext == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            fail_seen   <= 1'b0;
            first_fail  <= '0;
            timeout_err <= 1'b0;
            group       <= '0;
            step        <= '0;
          end
        end
        FETCH: begin
          // ROM data for word i arrives one cycle after its read
          if (step != 4'd0) ptBuf[step[2:0] - 3'd1] <= gf.pt_rdata;
          if (step == 4'd8) begin
            step           <= '0;
            gf.gf_reset    <= 1'b0;
            {gf.X, gf.Y}   <= ptBuf[0];
          end else begin
            step <= step + 4'd1;
          end
        end
        SEND: begin
          if (step == 4'd6) begin
            step     <= '0;
            gf.X     <= '0;
            gf.Y     <= '0;
            watchdog <= '0;
          end else begin
            step         <= step + 4'd1;
            {gf.X, gf.Y} <= ptBuf[step[2:0] + 3'd1];
          end
        end
        WAIT: begin
          watchdog <= watchdog + WDW'(1);
          if (groupEnd) begin
            gf.gf_reset <= 1'b1;
            step        <= '0;
            if (!lastGroup) group <= group + GW'(1);
            if (isFail) begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
              if (!fail_seen) begin
                fail_seen  <= 1'b1;
                first_fail <= group;
              end
            end else if (pass_cnt != '1) begin
              pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (timeoutHit) timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_geofence_host.sv
// tb/tb_geofence_host.sv - randomized self-checking bench for geofence_host
module tb_geofence_host;
  localparam int NG = 4;
  localparam int AW = 7;
  localparam int TO = 16;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, fail_seen, timeout_err;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [AW-4:0] first_fail;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  geofence_host_if #(.ADDR_W(AW)) gfIf ();

  geofence_host #(.NUM_GROUPS(NG), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .gf(gfIf),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_seen(fail_seen), .first_fail(first_fail), .timeout_err(timeout_err)
  );

  // external sync ROM
  logic [19:0] rom [0:127];
  logic [19:0] romData = '0;
  always @(posedge clk) if (gfIf.pt_rd) romData <= rom[gfIf.pt_addr];
  assign gfIf.pt_rdata = romData;

  // engine stand-in: records the 7 streamed points, then answers per group config
  logic respValid = 1'b0, respInside = 1'b0, injValid = 1'b0, injInside = 1'b0;
  assign gfIf.valid     = respValid | injValid;
  assign gfIf.is_inside = respValid ? respInside : injInside;

  bit cfgSilent [NG];
  bit cfgAns    [NG];
  int cfgDelay  [NG];
  int sampCnt = 0, waitCnt = 0, curGroup = 0;
  logic [19:0]   ptQ [$];
  logic [AW-1:0] addrQ [$];

  always @(negedge clk) begin
    if (gfIf.pt_rd) begin
      addrQ.push_back(gfIf.pt_addr);
      curGroup = int'(gfIf.pt_addr[AW-1:3]);
    end
    if (gfIf.gf_reset) begin
      sampCnt = 0; waitCnt = 0; respValid = 1'b0;
    end else if (sampCnt < 7) begin
      ptQ.push_back({gfIf.X, gfIf.Y});
      sampCnt++;
    end else begin
      respValid = 1'b0;
      if (!cfgSilent[curGroup] && waitCnt == cfgDelay[curGroup]) begin
        respValid  = 1'b1;
        respInside = cfgAns[curGroup];
      end
      waitCnt++;
    end
  end

  task automatic fillRom();
    for (int i = 0; i < 128; i++) rom[i] = 20'($urandom);
  endtask

  // mode 0: all answer correctly, 1: random incl. silent, 2: random no silent
  task automatic makeCfg(input int mode);
    for (int g = 0; g < NG; g++) begin
      cfgSilent[g] = (mode == 1) && ($urandom_range(0, 3) == 0);
      cfgAns[g]    = (mode == 0) ? rom[g*8+7][0] : 1'($urandom);
      cfgDelay[g]  = $urandom_range(0, TO - 1);
    end
  endtask

  task automatic startRun();
    ptQ.delete();
    addrQ.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitLow(input string name, input int limit);
    int n = 0;
    while (gfIf.gf_reset !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (gfIf.gf_reset !== 1'b0) begin
      errors++; $display("FAIL %s gf_reset release: got %b expected 0", name, gfIf.gf_reset);
    end
  endtask

  task automatic checkRun(input string name);
    int n = 0, expPass = 0, expFail = 0, expFirst = 0;
    bit expTo = 0, expSeen = 0, bad;
    for (int g = 0; g < NG; g++) begin
      bad = cfgSilent[g] || (cfgAns[g] != rom[g*8+7][0]);
      if (cfgSilent[g]) expTo = 1;
      if (bad) begin
        expFail++;
        if (!expSeen) begin expSeen = 1; expFirst = g; end
      end else expPass++;
    end
    if (expPass > CNT_MAX) expPass = CNT_MAX;
    if (expFail > CNT_MAX) expFail = CNT_MAX;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b expected 1", name, done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", name, busy); end
    checks++;
    if (pass_cnt !== CW'(expPass)) begin
      errors++; $display("FAIL %s pass_cnt: got %0d expected %0d", name, pass_cnt, expPass);
    end
    checks++;
    if (fail_cnt !== CW'(expFail)) begin
      errors++; $display("FAIL %s fail_cnt: got %0d expected %0d", name, fail_cnt, expFail);
    end
    checks++;
    if (fail_seen !== expSeen || first_fail !== (AW-3)'(expFirst)) begin
      errors++; $display("FAIL %s fail_seen/first_fail: got %b/%0d expected %b/%0d",
                         name, fail_seen, first_fail, expSeen, expFirst);
    end
    checks++;
    if (timeout_err !== expTo) begin
      errors++; $display("FAIL %s timeout_err: got %b expected %b", name, timeout_err, expTo);
    end
    bad = (addrQ.size() != NG*8);
    for (int i = 0; i < addrQ.size() && !bad; i++) if (addrQ[i] !== AW'(i)) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL %s pt_addr sequence: got %0d reads expected %0d in order", name, addrQ.size(), NG*8); end
    bad = (ptQ.size() != NG*7);
    for (int i = 0; i < ptQ.size() && !bad; i++) if (ptQ[i] !== rom[(i/7)*8 + (i%7)]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL %s X/Y stream: got %0d points expected %0d matching ROM", name, ptQ.size(), NG*7); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gfIf.gf_reset !== 1'b1 || gfIf.X !== 10'd0 || gfIf.Y !== 10'd0 || busy !== 1'b0 || done !== 1'b0 ||
        pass_cnt !== '0 || fail_cnt !== '0 || gfIf.pt_rd !== 1'b0 || gfIf.pt_addr !== '0 ||
        fail_seen !== 1'b0 || first_fail !== '0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset state: got gf_reset=%b X=%0d Y=%0d busy=%b done=%b pass=%0d fail=%0d pt_rd=%b expected 1/0/0/0/0/0/0/0",
                         gfIf.gf_reset, gfIf.X, gfIf.Y, busy, done, pass_cnt, fail_cnt, gfIf.pt_rd);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    fillRom(); makeCfg(0);
    startRun(); checkRun("all_pass");
  endtask

  task automatic test_mismatch();
    fillRom(); makeCfg(0);
    cfgAns[0] = ~rom[7][0];
    cfgAns[2] = ~rom[23][0];
    startRun(); checkRun("mismatch");
  endtask

  task automatic test_timeout();
    int n = 0;
    fillRom(); makeCfg(0);
    cfgSilent[0] = 1;
    startRun();
    waitLow("timeout", 50);
    while (gfIf.gf_reset === 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 7 + TO) begin errors++; $display("FAIL timeout gf_reset low cycles: got %0d expected %0d", n, 7 + TO); end
    checks++;
    if (fail_cnt !== CW'(1) || timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout immediate: got fail_cnt=%0d timeout_err=%b expected 1/1", fail_cnt, timeout_err);
    end
    checkRun("timeout");
  endtask

  task automatic test_ignore();
    int n = 0;
    fillRom(); makeCfg(2);
    startRun();
    while (!(gfIf.pt_rd === 1'b1 && gfIf.pt_addr[AW-1:3] == 1) && n < 200) begin @(negedge clk); n++; end
    injInside = ~rom[15][0];
    injValid  = 1'b1;
    @(negedge clk) injValid = 1'b0;
    waitLow("ignore", 50);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checkRun("ignore");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fillRom(); makeCfg(0);
    startRun();
    while (!(gfIf.pt_rd === 1'b1 && gfIf.pt_addr[AW-1:3] == 1) && n < 200) begin @(negedge clk); n++; end
    waitLow("reset_mid", 50);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gfIf.gf_reset !== 1'b1 || gfIf.X !== 10'd0 || gfIf.Y !== 10'd0 ||
        pass_cnt !== '0 || fail_cnt !== '0 || gfIf.pt_rd !== 1'b0) begin
      errors++; $display("FAIL reset_mid state: got busy=%b done=%b gf_reset=%b X=%0d Y=%0d pass=%0d fail=%0d expected 0/0/1/0/0/0/0",
                         busy, done, gfIf.gf_reset, gfIf.X, gfIf.Y, pass_cnt, fail_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    makeCfg(1);
    startRun(); checkRun("reset_mid_rerun");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      fillRom(); makeCfg(1);
      startRun(); checkRun($sformatf("random%0d", r));
    end
  endtask

  initial begin
    for (int g = 0; g < NG; g++) begin cfgSilent[g] = 0; cfgAns[g] = 0; cfgDelay[g] = 0; end
    fillRom();
    test_reset();
    test_all_pass();
    test_mismatch();
    test_timeout();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
